// File: rtl/fetch_inst_queue.sv
// Instruction fetch queue between the PC generator and decode.
// Splits each 8-byte fetch block into one or two PC-tagged 32-bit
// instructions, buffers them in a circular array and hands them to decode
// one per cycle. Stall is raised while fewer than two slots are free, so an
// accepted block always fits.
module fetch_inst_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_fetch_valid,
  input  logic [XLEN-1:0]          i_fetch_pc,
  input  logic [63:0]              i_fetch_data,
  output logic                     o_fq_stall,
  output logic                     o_inst_valid,
  output logic [31:0]              o_inst,
  output logic [XLEN-1:0]          o_inst_pc,
  input  logic                     i_dec_ready,
  output logic [$clog2(DEPTH):0]   o_fq_count,
  output logic                     o_fq_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  fq_entry_t [DEPTH-1:0] mem;

  logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
  logic [CW-1:0] count, free_slots, push_n;
  logic          drop_q;
  logic          push, pop, two_inst;

  assign free_slots = CW'(DEPTH) - count;
  assign o_fq_stall = free_slots < CW'(2);

  assign push     = i_fetch_valid & ~o_fq_stall & ~i_flush;
  assign two_inst = ~i_fetch_pc[2];
  assign push_n   = push ? (two_inst ? CW'(2) : CW'(1)) : '0;
  assign pop      = o_inst_valid & i_dec_ready;

  assign wr_ptr_p1 = wr_ptr + AW'(1);

  assign o_inst_valid = (count != '0);
  assign o_inst       = mem[rd_ptr].inst;
  assign o_inst_pc    = mem[rd_ptr].pc;
  assign o_fq_count   = count;
  assign o_fq_drop    = drop_q;

  // Storage write: aligned block fills two consecutive slots, odd half fills one.
  always_ff @(posedge i_clk) begin
    if (push) begin
      if (two_inst) begin
        mem[wr_ptr]    <= '{inst: i_fetch_data[31:0],  pc: i_fetch_pc};
        mem[wr_ptr_p1] <= '{inst: i_fetch_data[63:32], pc: i_fetch_pc + XLEN'(4)};
      end else begin
        mem[wr_ptr]    <= '{inst: i_fetch_data[63:32], pc: i_fetch_pc};
      end
    end
  end

  // Pointers, occupancy and drop pulse; reset beats flush beats push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_q <= 1'b0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_q <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + push_n[AW-1:0];
      count  <= count + push_n - CW'(pop);
      drop_q <= i_fetch_valid & o_fq_stall;
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Bench for fetch_inst_queue: directed stimulus pushes expected head entries
// into a scoreboard queue; a negedge monitor checks the head against it and
// retires entries on every decode handshake.
module tb_fetch_inst_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_flush = 1'b0;
  logic            i_fetch_valid = 1'b0;
  logic [XLEN-1:0] i_fetch_pc = '0;
  logic [63:0]     i_fetch_data = '0;
  logic            o_fq_stall;
  logic            o_inst_valid;
  logic [31:0]     o_inst;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_dec_ready = 1'b0;
  logic [3:0]      o_fq_count;
  logic            o_fq_drop;

  fetch_inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .i_fetch_data(i_fetch_data), .o_fq_stall(o_fq_stall),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_dec_ready(i_dec_ready), .o_fq_count(o_fq_count), .o_fq_drop(o_fq_drop)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: head must match scoreboard front; handshake retires it.
  always @(negedge i_clk) begin
    if (!i_rst && o_inst_valid !== 1'bx) begin
      chk("mon_valid", 64'(o_inst_valid), 64'(sbq.size() != 0));
      if (o_inst_valid && sbq.size() != 0) begin
        chk("mon_inst", 64'(o_inst), 64'(sbq[0].inst));
        chk("mon_pc",   64'(o_inst_pc), 64'(sbq[0].pc));
        if (i_dec_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one fetch block for a cycle; on acceptance record the split result.
  task automatic fetch(input logic [31:0] pc, input logic [63:0] data, input bit accept);
    i_fetch_valid = 1'b1;
    i_fetch_pc    = pc;
    i_fetch_data  = data;
    @(posedge i_clk);
    if (accept) begin
      if (pc[2] == 1'b0) begin
        sbq.push_back('{inst: data[31:0],  pc: pc});
        sbq.push_back('{inst: data[63:32], pc: pc + 32'd4});
      end else begin
        sbq.push_back('{inst: data[63:32], pc: pc});
      end
    end
    #1;
    i_fetch_valid = 1'b0;
  endtask

  task automatic pops(input int n);
    i_dec_ready = 1'b1;
    repeat (n) tick();
    i_dec_ready = 1'b0;
  endtask

  function automatic logic [63:0] blk(input logic [31:0] pc);
    return {pc ^ 32'h5A5A_0004, pc ^ 32'h5A5A_0000};
  endfunction

  initial begin
    // Reset
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_count", 64'(o_fq_count), 64'd0);
    chk("rst_valid", 64'(o_inst_valid), 64'd0);
    chk("rst_stall", 64'(o_fq_stall), 64'd0);
    chk("rst_drop",  64'(o_fq_drop), 64'd0);

    // Aligned block
    fetch(32'h8000_0000, 64'h00B3_0313_0010_0093, 1'b1);
    chk("al_count", 64'(o_fq_count), 64'd2);
    chk("al_inst",  64'(o_inst), 64'h0010_0093);
    chk("al_pc",    64'(o_inst_pc), 64'h8000_0000);
    pops(1);
    chk("al_count1", 64'(o_fq_count), 64'd1);
    chk("al_inst1",  64'(o_inst), 64'h00B3_0313);
    chk("al_pc1",    64'(o_inst_pc), 64'h8000_0004);
    pops(1);
    chk("al_empty", 64'(o_fq_count), 64'd0);

    // Half block
    fetch(32'h8000_0004, 64'hDEAD_BEEF_1111_1111, 1'b1);
    chk("hb_count", 64'(o_fq_count), 64'd1);
    chk("hb_inst",  64'(o_inst), 64'hDEAD_BEEF);
    chk("hb_pc",    64'(o_inst_pc), 64'h8000_0004);
    pops(1);

    // Fill, stall and drop
    fetch(32'h1000, blk(32'h1000), 1'b1);
    fetch(32'h1008, blk(32'h1008), 1'b1);
    fetch(32'h1010, blk(32'h1010), 1'b1);
    chk("fill_count6", 64'(o_fq_count), 64'd6);
    chk("fill_stall6", 64'(o_fq_stall), 64'd0);
    fetch(32'h1018, blk(32'h1018), 1'b1);
    chk("fill_count8", 64'(o_fq_count), 64'd8);
    chk("fill_stall8", 64'(o_fq_stall), 64'd1);
    fetch(32'h1020, blk(32'h1020), 1'b0);
    chk("drop_pulse", 64'(o_fq_drop), 64'd1);
    chk("drop_count", 64'(o_fq_count), 64'd8);
    tick();
    chk("drop_clear", 64'(o_fq_drop), 64'd0);
    pops(1);
    chk("pop7_count", 64'(o_fq_count), 64'd7);
    chk("pop7_stall", 64'(o_fq_stall), 64'd1);
    pops(1);
    chk("pop6_count", 64'(o_fq_count), 64'd6);
    chk("pop6_stall", 64'(o_fq_stall), 64'd0);
    pops(6);
    chk("fill_empty", 64'(o_fq_count), 64'd0);

    // Wrap with concurrent push/pop: 32 entries through an 8-deep ring
    i_dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fetch(32'h100 + 32'(8 * i), blk(32'h100 + 32'(8 * i)), 1'b1);
      chk("wrap_cnt_push", 64'(o_fq_count), 64'd2);
      tick();
      chk("wrap_cnt_idle", 64'(o_fq_count), 64'd1);
    end
    tick();
    i_dec_ready = 1'b0;
    chk("wrap_empty", 64'(o_fq_count), 64'd0);
    chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

    // Flush mid-operation with a same-cycle fetch
    fetch(32'h3000, blk(32'h3000), 1'b1);
    fetch(32'h3008, blk(32'h3008), 1'b1);
    fetch(32'h3014, blk(32'h3010), 1'b1);
    chk("fl_count5", 64'(o_fq_count), 64'd5);
    i_flush       = 1'b1;
    i_fetch_valid = 1'b1;
    i_fetch_pc    = 32'h4000;
    i_fetch_data  = blk(32'h4000);
    @(posedge i_clk);
    sbq.delete();
    #1;
    i_flush       = 1'b0;
    i_fetch_valid = 1'b0;
    chk("fl_count", 64'(o_fq_count), 64'd0);
    chk("fl_valid", 64'(o_inst_valid), 64'd0);
    chk("fl_stall", 64'(o_fq_stall), 64'd0);
    chk("fl_drop",  64'(o_fq_drop), 64'd0);
    fetch(32'h2000, blk(32'h2000), 1'b1);
    chk("fl_after_pc", 64'(o_inst_pc), 64'h2000);
    chk("fl_after_count", 64'(o_fq_count), 64'd2);
    pops(2);

    // Reset dominates flush and push
    fetch(32'h5000, blk(32'h5000), 1'b1);
    fetch(32'h5008, blk(32'h5008), 1'b1);
    chk("rf_count4", 64'(o_fq_count), 64'd4);
    i_rst         = 1'b1;
    i_flush       = 1'b1;
    i_fetch_valid = 1'b1;
    i_fetch_pc    = 32'h6000;
    i_fetch_data  = blk(32'h6000);
    @(posedge i_clk);
    sbq.delete();
    #1;
    i_rst         = 1'b0;
    i_flush       = 1'b0;
    i_fetch_valid = 1'b0;
    chk("rf_count", 64'(o_fq_count), 64'd0);
    chk("rf_valid", 64'(o_inst_valid), 64'd0);
    chk("rf_stall", 64'(o_fq_stall), 64'd0);
    chk("rf_drop",  64'(o_fq_drop), 64'd0);
    tick();
    chk("rf_drop2", 64'(o_fq_drop), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
